// File: rtl/count_chk_pkg.sv
// Shared types and default sizing for the count sequence checker and the counter bench.
package count_chk_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    HALTED  = 2'd3
  } chk_state_e;

  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_LOCK_CYCLES = 2;
  localparam int unsigned DEF_ERR_CNT_W   = 8;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/count_sequence_checker.sv
// Passive checker confirming count_in advances by exactly +1 per enabled sample.
// Optional macro CNT_CHK_WRAP_STOP_EN: halt (done=1) on the first wrap seen while locked.
module count_sequence_checker
  import count_chk_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter int ERR_CNT_W   = DEF_ERR_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [WIDTH-1:0]     count_in,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 wrap_pulse,
  output logic [WIDTH-1:0]     expected
`ifdef CNT_CHK_WRAP_STOP_EN
  ,
  output logic                 done
`endif
);

  localparam int MC_W = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);

  // en qualifies count_in: a sample is taken on every rising edge with en=1.
  // There is no ready/back-pressure; the checker always accepts.

  chk_state_e       state, state_n;
  logic [MC_W-1:0]  match_cnt, match_cnt_n;
  logic [WIDTH-1:0] expected_n;
  logic             locked_n, err_pulse_n, wrap_pulse_n, err_inc, match;
`ifdef CNT_CHK_WRAP_STOP_EN
  logic             done_n;
`endif

  // expected already holds prev+1, so a match is a direct compare against it.
  assign match = (count_in == expected);

  always_comb begin
    state_n      = state;
    match_cnt_n  = match_cnt;
    expected_n   = expected;
    locked_n     = locked;
    err_pulse_n  = 1'b0;
    wrap_pulse_n = 1'b0;
    err_inc      = 1'b0;
`ifdef CNT_CHK_WRAP_STOP_EN
    done_n       = done;
`endif
    if (en) begin
      case (state)
        IDLE: begin
          state_n     = ACQUIRE;
          expected_n  = count_in + WIDTH'(1);
          match_cnt_n = '0;
        end
        ACQUIRE: begin
          expected_n = count_in + WIDTH'(1);
          if (match) begin
            if (match_cnt == MC_W'(LOCK_CYCLES - 1)) begin
              state_n     = LOCKED;
              locked_n    = 1'b1;
              match_cnt_n = '0;
            end else begin
              match_cnt_n = match_cnt + MC_W'(1);
            end
          end else begin
            match_cnt_n = '0;
          end
        end
        LOCKED: begin
          expected_n = count_in + WIDTH'(1);
          if (match) begin
            if (count_in == '0) begin
              wrap_pulse_n = 1'b1;
`ifdef CNT_CHK_WRAP_STOP_EN
              state_n      = HALTED;
              done_n       = 1'b1;
`endif
            end
          end else begin
            err_pulse_n = 1'b1;
            err_inc     = 1'b1;
            locked_n    = 1'b0;
            state_n     = ACQUIRE;
            match_cnt_n = '0;
          end
        end
        HALTED: begin
          state_n = HALTED;
        end
        default: begin
          state_n = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      match_cnt  <= '0;
      expected   <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
`ifdef CNT_CHK_WRAP_STOP_EN
      done       <= 1'b0;
`endif
    end else begin
      state      <= state_n;
      match_cnt  <= match_cnt_n;
      expected   <= expected_n;
      locked     <= locked_n;
      err_pulse  <= err_pulse_n;
      wrap_pulse <= wrap_pulse_n;
`ifdef CNT_CHK_WRAP_STOP_EN
      done       <= done_n;
`endif
    end
  end

  sat_counter #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (err_inc),
    .count(err_count)
  );

endmodule
